// File: rtl/bank_pkg.sv
// Shared state type and default timing constants for the row_buffer_bank DRAM bank model.
package bank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVATING,
        OPEN,
        PRECHARGE
    } bank_state_t;

    localparam int T_RCD_DEF = 2;
    localparam int T_RP_DEF  = 2;
    localparam int CL_DEF    = 2;

    // Wide enough for any practical tRCD/tRP setting.
    localparam int CNT_W = 8;

endpackage

// File: rtl/rd_latency_pipe.sv
// Fixed-latency read return pipe: STAGES-deep shift of data and valid.
// The last stage only loads on a valid word, so it holds the previous read result.
module rd_latency_pipe #(
    parameter int DATA_W = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] data_p [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
        end else begin
            vld_p[0] <= in_vld;
            if (in_vld) data_p[0] <= in_data;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/row_buffer_bank.sv
// Single DRAM-style bank: activate/precharge timing, open-row access checks, CL-latency reads.
// Optional ROW_BUFFER_AUTO_PRECHARGE_EN closes the row after every accepted access.
module row_buffer_bank
    import bank_pkg::*;
#(
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8,
    parameter int DATA_W = 8,
    parameter int T_RCD  = T_RCD_DEF,
    parameter int T_RP   = T_RP_DEF,
    parameter int CL     = CL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act,
    input  logic              rd,
    input  logic              wr,
    input  logic [ROW_W-1:0]  addr_row_w,
    input  logic [COL_W-1:0]  addr_col_w,
    input  logic [ROW_W-1:0]  addr_row_r,
    input  logic [COL_W-1:0]  addr_col_r,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << (ROW_W + COL_W);

    bank_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rd_en, wr_en;
    logic              rd_hit, wr_hit;
    logic [ROW_W-1:0]  act_row;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_p0;

    assign act_row = wr ? addr_row_w : addr_row_r;
    assign rd_hit  = rd && (addr_row_r == open_row_q);
    assign wr_hit  = wr && (addr_row_w == open_row_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            open_row_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            open_row_q <= open_row_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        open_row_d = open_row_q;
        err_d      = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (act) begin
                    open_row_d = act_row;
                    cnt_d      = CNT_W'(T_RCD - 1);
                    state_d    = ACTIVATING;
                end else begin
                    err_d = rd || wr;
                end
            end
            ACTIVATING: begin
                err_d = act || rd || wr;
                if (cnt_q == '0) state_d = OPEN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            PRECHARGE: begin
                err_d = act || rd || wr;
                if (cnt_q == '0) begin
`ifdef ROW_BUFFER_AUTO_PRECHARGE_EN
                    state_d = IDLE;
`else
                    cnt_d   = CNT_W'(T_RCD - 1);
                    state_d = ACTIVATING;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OPEN: begin
`ifdef ROW_BUFFER_AUTO_PRECHARGE_EN
                // An act riding along with an accepted access is harmless; alone it is misuse.
                rd_en = rd_hit;
                wr_en = wr_hit;
                err_d = (rd && !rd_hit) || (wr && !wr_hit) || (act && !(rd_hit || wr_hit));
                if (rd_hit || wr_hit) begin
                    cnt_d   = CNT_W'(T_RP - 1);
                    state_d = PRECHARGE;
                end
`else
                if (act && (act_row != open_row_q)) begin
                    open_row_d = act_row;
                    cnt_d      = CNT_W'(T_RP - 1);
                    state_d    = PRECHARGE;
                end else begin
                    rd_en = rd_hit;
                    wr_en = wr_hit;
                    err_d = (rd && !rd_hit) || (wr && !wr_hit);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == ACTIVATING) || (state_d == PRECHARGE);
    end

    // Array read is combinational ahead of the write edge, giving read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{open_row_q, addr_col_w}] <= wdata;
    end

    assign rd_word_p0 = mem[{open_row_q, addr_col_r}];

    rd_latency_pipe #(
        .DATA_W (DATA_W),
        .STAGES (CL)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst),
        .in_vld   (rd_en),
        .in_data  (rd_word_p0),
        .out_vld  (rvalid),
        .out_data (rdata)
    );

    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_row_buffer_bank.sv
// Scoreboard bench for row_buffer_bank (default open-page build, T_RCD=2, T_RP=2, CL=2).
module tb_row_buffer_bank;

    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int CL    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       act, rd, wr;
    logic [7:0] addr_row_w, addr_col_w, addr_row_r, addr_col_r, wdata;
    logic [7:0] rdata;
    logic       rvalid, busy, err;

    row_buffer_bank #(
        .ROW_W(8), .COL_W(8), .DATA_W(8), .T_RCD(T_RCD), .T_RP(T_RP), .CL(CL)
    ) dut (
        .clk(clk), .rst(rst), .act(act), .rd(rd), .wr(wr),
        .addr_row_w(addr_row_w), .addr_col_w(addr_col_w),
        .addr_row_r(addr_row_r), .addr_col_r(addr_col_r),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [7:0] data; bit known; } rd_exp_t;
    typedef struct { bit busy; bit err; } ctrl_exp_t;

    rd_exp_t   rd_q[$];
    ctrl_exp_t ctrl_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: bank is either closed, busy for a number of cycles, or holding an open row.
    int         busy_left = 0;
    bit         has_row   = 0;
    logic [7:0] cur_row   = '0;
    logic [7:0] mdl_mem [int];
    logic [7:0] hold      = '0;
    bit         hold_known = 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_step(input bit a, input bit r, input bit w,
                              input logic [7:0] rw, input logic [7:0] cw,
                              input logic [7:0] rr, input logic [7:0] cr,
                              input logic [7:0] d);
        bit e_err;
        logic [7:0] tgt;
        rd_exp_t re;
        cyc++;
        e_err = 0;
        tgt = w ? rw : rr;
        if (busy_left > 0) begin
            e_err = a | r | w;
            busy_left--;
        end else if (!has_row) begin
            if (a) begin
                has_row   = 1;
                cur_row   = tgt;
                busy_left = T_RCD;
            end else begin
                e_err = r | w;
            end
        end else if (a && tgt != cur_row) begin
            cur_row   = tgt;
            busy_left = T_RP + T_RCD;
        end else begin
            if (r) begin
                if (rr == cur_row) begin
                    re.due   = cyc + CL - 1;
                    re.known = mdl_mem.exists({rr, cr});
                    re.data  = re.known ? mdl_mem[{rr, cr}] : 8'h00;
                    rd_q.push_back(re);
                end else begin
                    e_err = 1;
                end
            end
            if (w) begin
                if (rw == cur_row) mdl_mem[{rw, cw}] = d;
                else               e_err = 1;
            end
        end
        ctrl_q.push_back('{busy: (busy_left > 0), err: e_err});
    endtask

    task automatic cycle(input bit a, input bit r, input bit w,
                         input logic [7:0] rw, input logic [7:0] cw,
                         input logic [7:0] rr, input logic [7:0] cr,
                         input logic [7:0] d);
        act = a; rd = r; wr = w;
        addr_row_w = rw; addr_col_w = cw; addr_row_r = rr; addr_col_r = cr; wdata = d;
        @(posedge clk);
        model_step(a, r, w, rw, cw, rr, cr, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_act(input logic [7:0] row);
        cycle(1, 0, 0, 8'h00, 8'h00, row, 8'h00, 8'h00);
    endtask

    task automatic do_wr(input logic [7:0] row, input logic [7:0] col, input logic [7:0] d);
        cycle(0, 0, 1, row, col, 8'h00, 8'h00, d);
    endtask

    task automatic do_rd(input logic [7:0] row, input logic [7:0] col);
        cycle(0, 1, 0, 8'h00, 8'h00, row, col, 8'h00);
    endtask

    task automatic rand_inputs();
        act = $urandom_range(0, 1); rd = $urandom_range(0, 1); wr = $urandom_range(0, 1);
        addr_row_w = $urandom; addr_col_w = $urandom; addr_row_r = $urandom;
        addr_col_r = $urandom; wdata = $urandom;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset_mid();
        #2;
        rst = 1'b0;
        rd_q.delete();
        ctrl_q.delete();
        has_row = 0; busy_left = 0; hold = '0; hold_known = 1;
        rand_inputs();
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 rand_inputs();
        end
        act = 0; rd = 0; wr = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every cycle pops the control expectation and checks the read return stream.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ctrl_q.size() > 0) begin
                ctrl_exp_t c;
                c = ctrl_q.pop_front();
                chk("busy", busy, c.busy);
                chk("err", err, c.err);
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk("rvalid", rvalid, 1);
                if (e.known) chk("rdata", rdata, e.data);
                hold = e.data;
                hold_known = e.known;
            end else begin
                chk("rvalid_idle", rvalid, 0);
                if (hold_known) chk("rdata_hold", rdata, hold);
            end
        end
    end

    initial begin
        rst = 1'b0;
        act = 0; rd = 0; wr = 0;
        addr_row_w = '0; addr_col_w = '0; addr_row_r = '0; addr_col_r = '0; wdata = '0;
        #3;
        chk("init_rdata", rdata, 0);
        chk("init_rvalid", rvalid, 0);
        chk("init_busy", busy, 0);
        chk("init_err", err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic activate, write, read
        cycle(1, 0, 1, 8'h05, 8'h10, 8'h00, 8'h00, 8'h00);
        idle(2);
        do_wr(8'h05, 8'h10, 8'hA5);
        do_rd(8'h05, 8'h10);
        idle(3);

        // Row miss on read and write, array untouched
        do_rd(8'h06, 8'h10);
        do_wr(8'h06, 8'h10, 8'hFF);
        idle(1);
        do_rd(8'h05, 8'h10);
        idle(3);

        // Row switch with access attempted while busy, then reopen
        do_act(8'h07);
        do_rd(8'h05, 8'h10);
        idle(4);
        do_act(8'h05);
        idle(4);
        do_rd(8'h05, 8'h10);
        idle(3);

        // Same-cycle read and write to one location
        cycle(0, 1, 1, 8'h05, 8'h10, 8'h05, 8'h10, 8'h3C);
        do_rd(8'h05, 8'h10);
        idle(3);

        // Reset while a read is in flight
        do_rd(8'h05, 8'h10);
        do_reset_mid();
        do_rd(8'h05, 8'h10);
        idle(3);

        // Randomised traffic over a few rows and columns
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset_mid();
            cycle(($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                  8'($urandom_range(5, 7)), 8'($urandom_range(0, 3)),
                  8'($urandom_range(5, 7)), 8'($urandom_range(0, 3)), 8'($urandom));
        end
        idle(CL + 3);
        chk("drain_reads", rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
